quad_encoder_gen: RTL and testbench

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

---
 rtl/quadgen_pkg.sv | 17 +
 rtl/quadgen_phase_timer.sv | 27 ++
 rtl/quad_encoder_gen.sv | 145 ++++++++++++++
 tb/tb_quad_encoder_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadgen_pkg.sv
// Shared types and constants for the quadrature encoder generator.
package quadgen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // CW order of (B,A); index 0 is the reset state 00
   localparam logic [3:0][1:0] GRAY_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

   function automatic logic [1:0] next_phase(input logic [1:0] idx, input logic cw);
      return cw ? (idx + 2'd1) : (idx - 2'd1);
   endfunction

endpackage

// File: rtl/quadgen_phase_timer.sv
// Loadable down-counter; expire_c flags the counting cycle on which it sits at zero.
module quadgen_phase_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         count,
   input  logic [W-1:0] load_val,
   output logic         expire_c
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign expire_c = count && (count_q == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Step-driven quadrature encoder emulator with position counter.
// Optional push-button output enabled by defining QUADGEN_BUTTON_EN.
module quad_encoder_gen
   import quadgen_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES   = 1000,
   parameter int unsigned EDGES_PER_STEP = 4,
   parameter int unsigned POS_W          = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_valid,
   input  logic             step_dir,
   output logic             step_ready,
   output logic [1:0]       Encoder,
   output logic             busy,
   output logic [POS_W-1:0] Posicion
`ifdef QUADGEN_BUTTON_EN
   ,
   input  logic             btn_req,
   output logic             EncoderBoton
`endif
);

   // Wide enough for the longest duration loaded, the 4-phase button press
   localparam int unsigned TMR_W = $clog2(4 * PHASE_CYCLES);
   localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(PHASE_CYCLES - 1);
   localparam logic [1:0] LAST_EDGE = 2'(EDGES_PER_STEP - 1);

   state_t     state;
   logic       dir;
   logic [1:0] phase_idx;
   logic [1:0] edge_cnt;
   logic [1:0] nidx_c;
   logic       accept_c;
   logic       run_load_c;
   logic       run_count_c;
   logic       run_expire_c;

   always_comb begin
      accept_c    = 1'b0;
      run_load_c  = 1'b0;
      run_count_c = 1'b0;
      nidx_c      = next_phase(phase_idx, dir);
      accept_c    = (state == IDLE) && step_valid && step_ready;
      run_load_c  = accept_c || ((state == RUN) && run_expire_c);
      run_count_c = (state != IDLE);
   end

   quadgen_phase_timer #(.W(TMR_W)) u_run_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (run_load_c),
      .count    (run_count_c),
      .load_val (PHASE_LOAD),
      .expire_c (run_expire_c)
   );

   // Step FSM: each RUN expiry emits one Gray edge; HOLD pads one phase before IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dir        <= 1'b0;
         phase_idx  <= 2'd0;
         edge_cnt   <= 2'd0;
         Encoder    <= 2'b00;
         Posicion   <= '0;
         step_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  dir        <= step_dir;
                  edge_cnt   <= 2'd0;
                  state      <= RUN;
                  step_ready <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            RUN: begin
               if (run_expire_c) begin
                  phase_idx <= nidx_c;
                  Encoder   <= GRAY_SEQ[nidx_c];
                  if (edge_cnt == LAST_EDGE) begin
                     edge_cnt <= 2'd0;
                     state    <= HOLD;
                     Posicion <= dir ? (Posicion + POS_W'(1)) : (Posicion - POS_W'(1));
                  end else begin
                     edge_cnt <= edge_cnt + 2'd1;
                  end
               end
            end
            HOLD: begin
               if (run_expire_c) begin
                  state      <= IDLE;
                  step_ready <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               step_ready <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

`ifdef QUADGEN_BUTTON_EN
   localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(4 * PHASE_CYCLES - 1);

   logic btn_load_c;
   logic btn_count_c;
   logic btn_expire_c;

   always_comb begin
      btn_load_c  = 1'b0;
      btn_count_c = 1'b0;
      btn_load_c  = EncoderBoton && btn_req;
      btn_count_c = !EncoderBoton;
   end

   quadgen_phase_timer #(.W(TMR_W)) u_btn_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (btn_load_c),
      .count    (btn_count_c),
      .load_val (PRESS_LOAD),
      .expire_c (btn_expire_c)
   );

   // Active-low press; new requests are dropped until the press completes
   always_ff @(posedge clk) begin
      if (rst) begin
         EncoderBoton <= 1'b1;
      end else if (btn_load_c) begin
         EncoderBoton <= 1'b0;
      end else if (btn_expire_c) begin
         EncoderBoton <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen (PHASE_CYCLES=4).
// Button checks compile in when QUADGEN_BUTTON_EN is defined.
module tb_quad_encoder_gen;

   localparam int unsigned P     = 4;
   localparam int unsigned POS_W = 19;

   logic             clk = 1'b0;
   logic             rst;
   logic             step_valid, step_dir;
   logic             step_ready, busy;
   logic [1:0]       enc;
   logic [POS_W-1:0] pos;
   logic             step_valid1, step_dir1;
   logic             step_ready1, busy1;
   logic [1:0]       enc1;
   logic [POS_W-1:0] pos1;
`ifdef QUADGEN_BUTTON_EN
   logic             btn_req;
   logic             boton;
   logic             btn_req1;
   logic             boton1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   quad_encoder_gen #(.PHASE_CYCLES(P), .EDGES_PER_STEP(4), .POS_W(POS_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .step_valid (step_valid),
      .step_dir   (step_dir),
      .step_ready (step_ready),
      .Encoder    (enc),
      .busy       (busy),
      .Posicion   (pos)
`ifdef QUADGEN_BUTTON_EN
      ,
      .btn_req      (btn_req),
      .EncoderBoton (boton)
`endif
   );

   quad_encoder_gen #(.PHASE_CYCLES(P), .EDGES_PER_STEP(1), .POS_W(POS_W)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .step_valid (step_valid1),
      .step_dir   (step_dir1),
      .step_ready (step_ready1),
      .Encoder    (enc1),
      .busy       (busy1),
      .Posicion   (pos1)
`ifdef QUADGEN_BUTTON_EN
      ,
      .btn_req      (btn_req1),
      .EncoderBoton (boton1)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      n_checks++;
      if (step_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", step_ready); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++;
      if (enc !== 2'b00) begin n_fail++; $display("FAIL reset_enc got %b exp 00", enc); end
      n_checks++;
      if (pos !== '0) begin n_fail++; $display("FAIL reset_pos got %0d exp 0", pos); end
      n_checks++;
      if (step_ready1 !== 1'b1 || enc1 !== 2'b00) begin
         n_fail++; $display("FAIL reset_dut1 ready %b enc %b exp 1 00", step_ready1, enc1);
      end
`ifdef QUADGEN_BUTTON_EN
      n_checks++;
      if (boton !== 1'b1) begin n_fail++; $display("FAIL reset_boton got %b exp 1", boton); end
`endif
   endtask

   task automatic test_cw();
      logic [1:0] exp_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
      do_reset();
      step_valid = 1'b1; step_dir = 1'b1;
      tick();                       // acceptance edge
      step_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || step_ready !== 1'b0) begin
         n_fail++; $display("FAIL cw_accept busy %b ready %b exp 1 0", busy, step_ready);
      end
      for (int e = 0; e < 4; e++) begin
         repeat (P - 1) tick();
         n_checks++;
         if (enc !== (e == 0 ? 2'b00 : exp_seq[e-1])) begin
            n_fail++; $display("FAIL cw_hold_%0d got %b", e, enc);
         end
         // A request while busy must not be queued
         if (e == 2) begin step_valid = 1'b1; step_dir = 1'b0; end
         tick();
         step_valid = 1'b0;
         n_checks++;
         if (enc !== exp_seq[e]) begin
            n_fail++; $display("FAIL cw_edge_%0d got %b exp %b", e, enc, exp_seq[e]);
         end
      end
      n_checks++;
      if (pos !== 19'd1) begin n_fail++; $display("FAIL cw_pos got %0d exp 1", pos); end
      repeat (P - 1) tick();
      n_checks++;
      if (step_ready !== 1'b0) begin n_fail++; $display("FAIL cw_hold_ready got %b exp 0", step_ready); end
      tick();
      n_checks++;
      if (step_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL cw_done ready %b busy %b exp 1 0", step_ready, busy);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || pos !== 19'd1) begin
         n_fail++; $display("FAIL cw_no_queue busy %b pos %0d exp 0 1", busy, pos);
      end
   endtask

   task automatic test_ccw();
      logic [1:0] exp_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      do_reset();
      step_valid = 1'b1; step_dir = 1'b0;
      tick();
      step_valid = 1'b0;
      for (int e = 0; e < 4; e++) begin
         repeat (P) tick();
         n_checks++;
         if (enc !== exp_seq[e]) begin
            n_fail++; $display("FAIL ccw_edge_%0d got %b exp %b", e, enc, exp_seq[e]);
         end
      end
      n_checks++;
      if (pos !== 19'h7FFFF) begin n_fail++; $display("FAIL ccw_pos got %0d exp 524287", pos); end
      repeat (P) tick();
      n_checks++;
      if (step_ready !== 1'b1) begin n_fail++; $display("FAIL ccw_done got %b exp 1", step_ready); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step_valid = 1'b1; step_dir = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         n_checks++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_%0d busy %b exp 1", s, busy); end
         if (s == 2) step_valid = 1'b0;
         repeat (19) tick();
         n_checks++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_%0d busy %b exp 1", s, busy); end
         tick();
         n_checks++;
         if (step_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_%0d ready %b exp 1", s, step_ready); end
         if (s < 2) tick();
      end
      n_checks++;
      if (pos !== 19'd3 || enc !== 2'b00) begin
         n_fail++; $display("FAIL b2b_final pos %0d enc %b exp 3 00", pos, enc);
      end
      tick();
      n_checks++;
      if (step_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_no_extra ready %b exp 1", step_ready); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step_valid = 1'b1; step_dir = 1'b1;
      tick();
      step_valid = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (enc !== 2'b11) begin n_fail++; $display("FAIL mid_pre got %b exp 11", enc); end
      rst = 1'b1; step_valid = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (enc !== 2'b00 || pos !== '0 || step_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_abort enc %b pos %0d ready %b busy %b exp 00 0 1 0", enc, pos, step_ready, busy);
      end
      tick();                       // step_valid still high: accepted here
      step_valid = 1'b0;
      repeat (P) tick();
      n_checks++;
      if (enc !== 2'b01) begin n_fail++; $display("FAIL mid_restart got %b exp 01", enc); end
      repeat (3 * P) tick();
      n_checks++;
      if (enc !== 2'b00 || pos !== 19'd1) begin
         n_fail++; $display("FAIL mid_complete enc %b pos %0d exp 00 1", enc, pos);
      end
      repeat (P) tick();
   endtask

   task automatic test_edges1();
      logic [1:0] exp_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step_valid1 = 1'b1; step_dir1 = 1'b1;
         tick();
         step_valid1 = 1'b0;
         repeat (P) tick();
         n_checks++;
         if (enc1 !== exp_seq[k] || pos1 !== POS_W'(k + 1)) begin
            n_fail++;
            $display("FAIL e1_step_%0d enc %b pos %0d exp %b %0d", k, enc1, pos1, exp_seq[k], k + 1);
         end
         repeat (P) tick();
         n_checks++;
         if (step_ready1 !== 1'b1) begin n_fail++; $display("FAIL e1_ready_%0d got %b exp 1", k, step_ready1); end
      end
   endtask

`ifdef QUADGEN_BUTTON_EN
   task automatic test_button();
      do_reset();
      btn_req = 1'b1;
      tick();
      btn_req = 1'b0;
      n_checks++;
      if (boton !== 1'b0) begin n_fail++; $display("FAIL btn_start got %b exp 0", boton); end
      for (int i = 1; i <= 4 * P; i++) begin
         tick();
         btn_req = (i == 4);
         n_checks++;
         if (boton !== (i < 4 * P ? 1'b0 : 1'b1)) begin
            n_fail++; $display("FAIL btn_cyc_%0d got %b", i, boton);
         end
      end
      tick();
      n_checks++;
      if (boton !== 1'b1) begin n_fail++; $display("FAIL btn_release got %b exp 1", boton); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      step_valid = 1'b0; step_dir = 1'b0;
      step_valid1 = 1'b0; step_dir1 = 1'b0;
`ifdef QUADGEN_BUTTON_EN
      btn_req = 1'b0; btn_req1 = 1'b0;
`endif
      test_reset();
      test_cw();
      test_ccw();
      test_back_to_back();
      test_reset_mid();
      test_edges1();
`ifdef QUADGEN_BUTTON_EN
      test_button();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
